// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction fetch unit
// Optional burst fetching is enabled by defining FETCH_BURST_EN.
package fetch_pkg;

  localparam logic [1:0]  SZ_WORD      = 2'b00;
  localparam logic [1:0]  SZ_BURST4    = 2'b01;
  localparam logic [31:0] START_PC_DEF = 32'h8002_0000;
  localparam int          PC_W         = 32;
  localparam int          INSN_W       = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECV
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - PC-tagged instruction buffer with flush and free-slot count
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] free_cnt
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [CNT_W-1:0] w_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign empty    = (w_count == '0);
  assign full     = (w_count == CNT_W'(DEPTH));
  assign free_cnt = CNT_W'(DEPTH) - w_count;
  assign head     = r_mem[r_rd_ptr[PTR_W-1:0]];

  // A pop in the same cycle frees a slot for a push into a full buffer.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: credit-based memory requests into a tagged FIFO
// Define FETCH_BURST_EN to issue aligned 4-word bursts when enough credit is free.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] START_PC   = START_PC_DEF,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_access_size,
  output logic              mem_rw,
  output logic              mem_enable,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_data,
  output logic              insn_valid,
  output logic [DATA_W-1:0] insn,
  output logic [ADDR_W-1:0] insn_pc,
  input  logic              insn_ready
);

  localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LEN_WORD  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LEN_BURST = CNT_W'(4);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_tag_pc;
  logic [ADDR_W-1:0] r_mem_address;
  logic [1:0]        r_mem_size;
  logic              r_mem_enable;
  logic [CNT_W-1:0]  r_req_len;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_discard;

  logic [CNT_W-1:0]  w_free;
  logic [CNT_W-1:0]  w_credit;
  logic [CNT_W-1:0]  w_len;
  logic [CNT_W-1:0]  w_due;
  logic [1:0]        w_size;
  logic              w_full;
  logic              w_empty;
  logic              w_arrive;
  logic              w_accept;
  logic              w_can_issue;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_redirect_pc;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;

  // Outstanding words always fit in the free slots, so this never underflows.
  assign w_credit = w_full ? '0 : (w_free - r_outstanding);

  always_comb begin
    w_len  = LEN_WORD;
    w_size = SZ_WORD;
`ifdef FETCH_BURST_EN
    if (r_pc[3:2] == 2'b00 && w_credit >= LEN_BURST) begin
      w_len  = LEN_BURST;
      w_size = SZ_BURST4;
    end
`endif
  end

  assign w_arrive      = (r_outstanding != '0) || (r_discard != '0);
  assign w_accept      = r_mem_enable & ~mem_busy;
  assign w_can_issue   = (r_discard == '0) && (w_credit >= w_len);
  assign w_redirect_pc = redirect_pc & ~ADDR_W'(3);
  // Words the memory still owes after this cycle; they are dropped on arrival.
  assign w_due         = w_accept ? r_req_len
                                  : (r_outstanding + r_discard - CNT_W'(w_arrive));

  assign w_push       = (r_outstanding != '0) & ~redirect_valid;
  assign w_pop        = ~w_empty & insn_ready;
  assign w_push_entry = '{pc: r_tag_pc, insn: mem_data};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .free_cnt  (w_free)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_pc          <= START_PC;
      r_tag_pc      <= START_PC;
      r_mem_address <= START_PC;
      r_mem_size    <= SZ_WORD;
      r_mem_enable  <= 1'b0;
      r_req_len     <= LEN_WORD;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirect_valid) begin
      r_state       <= IDLE;
      r_mem_enable  <= 1'b0;
      r_pc          <= w_redirect_pc;
      r_outstanding <= '0;
      r_discard     <= w_due;
    end else begin
      if (r_discard != '0) r_discard <= r_discard - 1'b1;
      case (r_state)
        IDLE: begin
          if (w_can_issue) begin
            r_state       <= REQ;
            r_mem_enable  <= 1'b1;
            r_mem_address <= r_pc;
            r_mem_size    <= w_size;
            r_req_len     <= w_len;
          end
        end
        REQ: begin
          if (!mem_busy) begin
            r_state       <= RECV;
            r_mem_enable  <= 1'b0;
            r_pc          <= r_pc + (ADDR_W'(r_req_len) << 2);
            r_tag_pc      <= r_pc;
            r_outstanding <= r_req_len;
          end
        end
        RECV: begin
          r_outstanding <= r_outstanding - 1'b1;
          r_tag_pc      <= r_tag_pc + ADDR_W'(4);
          if (r_outstanding == LEN_WORD) begin
            if (w_can_issue) begin
              r_state       <= REQ;
              r_mem_enable  <= 1'b1;
              r_mem_address <= r_pc;
              r_mem_size    <= w_size;
              r_req_len     <= w_len;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_address     = r_mem_address;
  assign mem_access_size = r_mem_size;
  assign mem_enable      = r_mem_enable;
  assign mem_rw          = 1'b1;
  assign insn_valid      = ~w_empty;
  assign insn            = w_head.insn;
  assign insn_pc         = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a pipelined memory model
// Expected burst sizes follow FETCH_BURST_EN when it is defined for the build.
module tb_fetch_unit;

`ifdef FETCH_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] mem_address;
  logic [1:0]  mem_access_size;
  logic        mem_rw;
  logic        mem_enable;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_data = '0;
  logic        insn_valid;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_ready = 1'b0;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .mem_address     (mem_address),
    .mem_access_size (mem_access_size),
    .mem_rw          (mem_rw),
    .mem_enable      (mem_enable),
    .mem_busy        (mem_busy),
    .mem_data        (mem_data),
    .insn_valid      (insn_valid),
    .insn            (insn),
    .insn_pc         (insn_pc),
    .insn_ready      (insn_ready)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } pop_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic [1:0]  size_burst;
    logic [31:0] pc0;
    logic [31:0] insn0;
    logic [31:0] pc1;
    logic [31:0] insn1;
    int          delay;
  } vec_t;

  int          n_checks = 0;
  int          n_pass = 0;
  int          acc_count = 0;
  int          words_issued = 0;
  int          pops_total = 0;
  pop_t        pop_q[$];
  logic [31:0] rsp_q[$];
  logic        acc_pend = 1'b0;
  logic [31:0] acc_addr = '0;
  int          acc_len = 1;
  logic [31:0] exp_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8002_0000) return 32'h1111_1111;
    if (a == 32'h8002_0004) return 32'h2222_2222;
    return {a[15:0], 16'hC0DE};
  endfunction

  // Memory: requests seen at negedge, words driven one per cycle after the next posedge.
  always @(negedge clock) begin
    if (reset_n && mem_enable && !mem_busy) begin
      acc_pend     = 1'b1;
      acc_addr     = mem_address;
      acc_len      = (mem_access_size == 2'b01) ? 4 : 1;
      acc_count    = acc_count + 1;
      words_issued = words_issued + acc_len;
    end
    if (reset_n && insn_valid && insn_ready) begin
      pop_q.push_back({insn_pc, insn});
      pops_total = pops_total + 1;
    end
  end

  always @(posedge clock) begin
    #1;
    if (!reset_n) begin
      rsp_q.delete();
      acc_pend = 1'b0;
      mem_data = '0;
    end else begin
      if (acc_pend) begin
        for (int k = 0; k < acc_len; k++) rsp_q.push_back(mem_word(acc_addr + 32'(4 * k)));
        acc_pend = 1'b0;
      end
      mem_data = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'hDEAD_BEEF;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_enable(input int limit);
    for (int i = 0; i < limit && !mem_enable; i++) tick();
  endtask

  task automatic wait_accept(input int limit);
    int base;
    base = acc_count;
    for (int i = 0; i < limit && acc_count == base; i++) tick();
  endtask

  task automatic drain_check(input string tag);
    pop_t e;
    while (pop_q.size() > 0) begin
      e = pop_q.pop_front();
      check({tag, "_pc"}, e.pc, exp_pc);
      check({tag, "_insn"}, e.insn, mem_word(e.pc));
      exp_pc = e.pc + 32'd4;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"}, 32'(mem_enable), 32'd0);
    check({tag, "_addr"}, mem_address, 32'h8002_0000);
    check({tag, "_size"}, 32'(mem_access_size), 32'd0);
    check({tag, "_rw"}, 32'(mem_rw), 32'd1);
    check({tag, "_valid"}, 32'(insn_valid), 32'd0);
    check({tag, "_insn"}, insn, 32'd0);
    check({tag, "_insn_pc"}, insn_pc, 32'd0);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    insn_ready     = 1'b0;
    tick();
    redirect_valid = 1'b0;
    pop_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t  vecs[5];
    pop_t  e0;
    pop_t  e1;
    int    n_en;
    int    base;
    logic [31:0] a0;

    vecs[0] = '{32'h1234_5679, 32'h1234_5678, 2'b00, 32'h1234_5678, 32'h5678_C0DE, 32'h1234_567C, 32'h567C_C0DE, 0};
    vecs[1] = '{32'h8002_1006, 32'h8002_1004, 2'b00, 32'h8002_1004, 32'h1004_C0DE, 32'h8002_1008, 32'h1008_C0DE, 1};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 2'b00, 32'hFFFF_FFFC, 32'hFFFC_C0DE, 32'h0000_0000, 32'h0000_C0DE, 2};
    vecs[3] = '{32'h8002_0010, 32'h8002_0010, 2'b01, 32'h8002_0010, 32'h0010_C0DE, 32'h8002_0014, 32'h0014_C0DE, 0};
    vecs[4] = '{32'h8002_000B, 32'h8002_0008, 2'b00, 32'h8002_0008, 32'h0008_C0DE, 32'h8002_000C, 32'h000C_C0DE, 3};

    repeat (3) tick();
    check_reset_outputs("rst");
    reset_n    = 1'b1;
    insn_ready = 1'b1;

    wait_enable(10);
    check("first_req_en", 32'(mem_enable), 32'd1);
    check("first_req_addr", mem_address, 32'h8002_0000);
    check("first_req_size", 32'(mem_access_size), BURST ? 32'd1 : 32'd0);
    for (int i = 0; i < 20 && pop_q.size() < 2; i++) tick();
    check("first_pops", 32'(pop_q.size() >= 2), 32'd1);
    if (pop_q.size() >= 2) begin
      e0 = pop_q.pop_front();
      e1 = pop_q.pop_front();
      check("pop0_pc", e0.pc, 32'h8002_0000);
      check("pop0_insn", e0.insn, 32'h1111_1111);
      check("pop1_pc", e1.pc, 32'h8002_0004);
      check("pop1_insn", e1.insn, 32'h2222_2222);
    end
    exp_pc = 32'h8002_0008;

    insn_ready = 1'b0;
    n_en = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 10 && mem_enable) n_en = n_en + 1;
    end
    check("stall_no_req", 32'(n_en), 32'd0);
    check("stall_fifo_words", 32'(words_issued - pops_total), 32'd4);
    check("stall_valid", 32'(insn_valid), 32'd1);
    insn_ready = 1'b1;
    repeat (15) tick();
    drain_check("stall");
    check("stall_progress", 32'(pops_total >= 8), 32'd1);

    wait_enable(20);
    check("busy_req_seen", 32'(mem_enable), 32'd1);
    mem_busy = 1'b1;
    a0   = mem_address;
    base = acc_count;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("busy_en_hold", 32'(mem_enable), 32'd1);
      check("busy_addr_hold", mem_address, a0);
    end
    mem_busy = 1'b0;
    tick();
    check("busy_one_accept", 32'(acc_count), 32'(base + 1));
    repeat (12) tick();
    drain_check("busy");

    for (int v = 0; v < 5; v++) begin
      insn_ready = 1'b1;
      wait_accept(40);
      repeat (vecs[v].delay) tick();
      do_redirect(vecs[v].rpc);
      check("vec_flushed", 32'(insn_valid), 32'd0);
      wait_enable(40);
      check("vec_req_en", 32'(mem_enable), 32'd1);
      check("vec_req_addr", mem_address, vecs[v].exp_addr);
      check("vec_req_size", 32'(mem_access_size), BURST ? 32'(vecs[v].size_burst) : 32'd0);
      insn_ready = 1'b1;
      for (int i = 0; i < 20 && pop_q.size() < 2; i++) tick();
      check("vec_pops", 32'(pop_q.size() >= 2), 32'd1);
      if (pop_q.size() >= 2) begin
        e0 = pop_q.pop_front();
        e1 = pop_q.pop_front();
        check("vec_pc0", e0.pc, vecs[v].pc0);
        check("vec_insn0", e0.insn, vecs[v].insn0);
        check("vec_pc1", e1.pc, vecs[v].pc1);
        check("vec_insn1", e1.insn, vecs[v].insn1);
      end
    end

    do_redirect(32'h8002_0100);
    wait_enable(40);
    check("mid_req_addr", mem_address, 32'h8002_0100);
    check("mid_req_size", 32'(mem_access_size), BURST ? 32'd1 : 32'd0);
    wait_accept(10);
    tick();
    do_redirect(32'h8002_0043);
    check("mid_flushed", 32'(insn_valid), 32'd0);
    wait_enable(40);
    check("mid_new_en", 32'(mem_enable), 32'd1);
    check("mid_new_addr", mem_address, 32'h8002_0040);
    insn_ready = 1'b1;
    exp_pc = 32'h8002_0040;
    repeat (12) tick();
    check("mid_pops", 32'(pop_q.size() > 0), 32'd1);
    drain_check("mid");

    wait_accept(40);
    check("rst_mid_accept", 32'(mem_enable), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    tick();
    reset_n = 1'b1;
    wait_enable(10);
    check("rst_mid_restart", mem_address, 32'h8002_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the byte-addressable main memory. Drives the memory's address, access_size, rw and enable inputs, and collects returned words.
- Holds fetched words in a 4-entry FIFO tagged with their PC. Presents them to decode with a valid/ready handshake.
- Supports PC redirect from branch/jump resolution.

Parameters:
- START_PC, 32'h80020000, reset PC; equals memory base address.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, at least 4.
- ADDR_W, 32, address width.
- DATA_W, 32, instruction width.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0).
- mem_address  out  32  byte address to memory.
- mem_access_size  out  2  00 = 1 word, 01 = 4-word burst.
- mem_rw  out  1  always 1 (read).
- mem_enable  out  1  request strobe.
- mem_busy  in  1  memory stall; a request is accepted only on a cycle with mem_busy = 0.
- mem_data  in  32  returned word, big-endian as stored.
- insn_valid  out  1  FIFO head valid.
- insn  out  32  head instruction.
- insn_pc  out  32  head PC.
- insn_ready  in  1  decode accepts head this cycle.

Behaviour:
- Reset (async, reset_n = 0):
  - pc = START_PC; FIFO empty; discard_cnt = 0; state = IDLE.
  - mem_enable = 0, mem_address = START_PC, mem_access_size = 00, mem_rw = 1, insn_valid = 0, insn = 0, insn_pc = 0.
- Memory timing:
  - Request accepted on cycle N (mem_enable = 1, mem_busy = 0).
  - Word k of the access is on mem_data at cycle N+1+k.
  - Single access: k = 0. Burst: k = 0..3, consecutive cycles, addresses pc, pc+4, pc+8, pc+12.
- Credit rule:
  - Issue only if FIFO free slots minus outstanding words is at least the request length (1 or 4). The FIFO never overflows.
- States:
  - IDLE: if the credit rule is met and there is no redirect, go to REQ.
  - REQ: assert mem_enable with mem_address = pc.
    - Accepted: pc += 4·len; outstanding = len; go to RECV.
    - mem_busy: hold all outputs stable and stay in REQ.
  - RECV: push each returning word as {pc_tag, mem_data}; decrement outstanding.
    - Go to IDLE when outstanding reaches 0. A back-to-back REQ in the same cycle is allowed if the credit rule holds.
- Push and pop in the same cycle:
  - Legal when full: the pop frees a slot first.
  - Legal when empty only if bypass is not implemented. An empty FIFO with a push shows insn_valid the following cycle (no combinational bypass).
- Pop: insn_valid & insn_ready removes the head.
- Redirect, any state:
  - Next cycle: FIFO flushed, insn_valid = 0, pc = {redirect_pc[31:2], 2'b00}.
  - discard_cnt = outstanding words still due. Those words are dropped, not pushed.
  - Any REQ not yet accepted is abandoned.
  - New fetch may issue only once discard_cnt = 0.
  - A redirect on the same cycle as a pop: redirect wins; the pop is still counted as consumed by decode.
- Wrap-around: pc increments modulo 2^32; no special handling.
- Pointers: log2(FIFO_DEPTH) bits plus one wrap bit for the full/empty distinction.
- Reset mid-burst: all state cleared immediately; the memory is expected to be reset alongside.

Optional Feature:
- Macro FETCH_BURST_EN.
- Defined: issue a 4-word burst (access_size 01) when pc[3:2] = 00 and at least 4 credits are free. Otherwise issue a single word.
- Undefined: only single-word accesses (access_size 00); burst logic is not compiled.

Decomposition:
- Package fetch_pkg:
  - Access-size constants SZ_WORD = 2'b00, SZ_BURST4 = 2'b01.
  - State enum {IDLE, REQ, RECV}.
  - START_PC default.
  - Entry struct {pc, insn}.
- Sub-module fetch_fifo: synchronous FIFO with push, pop, flush, full, empty and free-count. Instantiated once.

Test Plan:
- Release reset, insn_ready = 1, memory holds 0x11111111 at 0x80020000 and 0x22222222 at 0x80020004 → first request has address 0x80020000, size 00; insn_pc sequence 0x80020000, 0x80020004 with matching insn values.
- Hold insn_ready = 0 for 20 cycles → at most 4 entries fetched, mem_enable stays 0 once credits are exhausted, no entry lost or duplicated after release.
- mem_busy high for 3 cycles during REQ → mem_address and mem_enable stable throughout; a single acceptance; no duplicate push.
- FETCH_BURST_EN defined, PC 0x80020000 → one request with size 01; four entries tagged 0x80020000 to 0x8002000C on 4 consecutive cycles.
- Redirect to 0x80020043 in the middle of a burst → remaining burst words discarded, FIFO flushed, next request address 0x80020040.
- Assert reset_n = 0 asynchronously mid-RECV → all outputs at their reset values before the next clock edge.
